ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl_if.sv | 28 ++
 rtl/ram_fifo_ctrl.sv | 69 ++++++
 tb/tb_ram_fifo_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Upstream push, downstream pop and RAM port signals shared by ram_fifo_ctrl and its environment.
// The master side is the surrounding system: producer, consumer and RAM.
interface ram_fifo_ctrl_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    logic          push;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          ram_wr;
    logic          ram_rd;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    modport master (
        output push, push_data, pop, ram_data_out,
        input  push_ready, pop_data, pop_valid, ram_wr, ram_rd, ram_add, ram_data_in
    );

    modport slave (
        input  push, push_data, pop, ram_data_out,
        output push_ready, pop_data, pop_valid, ram_wr, ram_rd, ram_add, ram_data_in
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external single-port RAM with a registered read port.
// Pop wins over push when both are requested; the RAM supplies read data one cycle after ram_rd.
module ram_fifo_ctrl #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    ram_fifo_ctrl_if.slave bus,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          pop_acc;
    logic          push_acc;
    logic          vld_p1;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);

    // Reset gates the accepts so the RAM is never strobed while the controller is being cleared.
    assign pop_acc  = bus.pop & ~empty & ~rst;
    assign push_acc = bus.push & ~full & ~pop_acc & ~rst;

    assign bus.push_ready  = ~rst & ~full & ~(bus.pop & ~empty);
    assign bus.ram_wr      = push_acc;
    assign bus.ram_rd      = pop_acc;
    assign bus.ram_add     = push_acc ? wptr : rptr;
    assign bus.ram_data_in = bus.push_data;
    assign bus.pop_data    = bus.ram_data_out;
    assign bus.pop_valid   = vld_p1;

    // Stage p1: the RAM has registered the read word on the same edge that sets vld_p1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            vld_p1 <= pop_acc;
            if (bus.push & full & ~pop_acc) begin
                overflow <= 1'b1;
            end
            if (bus.pop & empty) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: RAM model, queue-based reference model, directed and random stimulus.
module tb_ram_fifo_ctrl;
    localparam int DW = 4;
    localparam int AW = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    ram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with a registered read port; contents survive reset.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wr) mem[bus.ram_add] <= bus.ram_data_in;
        if (bus.ram_rd) bus.ram_data_out <= mem[bus.ram_add];
    end

    int total;
    int bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue; addresses follow from the number of pushes since reset.
    logic [DW-1:0] mq [$];
    int            wcount;
    bit            m_ovf;
    bit            m_uf;
    bit            exp_vld;
    logic [DW-1:0] exp_data;
    bit            ready;

    logic [DW-1:0] got [$];
    int            wadds [$];
    int            radds [$];

    int  sz;
    bit  me, mf, pacc, wacc;
    int  ra, wa;

    always @(negedge clk) begin
        if (ready) begin
            sz   = mq.size();
            me   = (sz == 0);
            mf   = (sz == DEPTH);
            pacc = bus.pop && !me && !rst;
            wacc = bus.push && !mf && !pacc && !rst;
            wa   = wcount % DEPTH;
            ra   = (wcount - sz) % DEPTH;
            chk("push_ready", 32'(bus.push_ready), 32'(!rst && !mf && !(bus.pop && !me)));
            chk("ram_wr", 32'(bus.ram_wr), 32'(wacc));
            chk("ram_rd", 32'(bus.ram_rd), 32'(pacc));
            chk("ram_add", 32'(bus.ram_add), 32'(wacc ? wa : ra));
            if (wacc) chk("ram_data_in", 32'(bus.ram_data_in), 32'(bus.push_data));
            chk("count", 32'(count), 32'(sz));
            chk("full", 32'(full), 32'(mf));
            chk("empty", 32'(empty), 32'(me));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_uf));
            chk("pop_valid", 32'(bus.pop_valid), 32'(exp_vld));
            if (exp_vld) chk("pop_data", 32'(bus.pop_data), 32'(exp_data));
            if (bus.pop_valid === 1'b1) got.push_back(bus.pop_data);
            if (bus.ram_wr === 1'b1) wadds.push_back(int'(bus.ram_add));
            if (bus.ram_rd === 1'b1) radds.push_back(int'(bus.ram_add));
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            wcount  = 0;
            m_ovf   = 0;
            m_uf    = 0;
            exp_vld = 0;
            ready   = 1;
        end else if (ready) begin
            if (bus.pop && mq.size() == 0) m_uf = 1;
            if (bus.pop && mq.size() != 0) begin
                exp_data = mq.pop_front();
                exp_vld  = 1;
            end else begin
                exp_vld = 0;
                if (bus.push && mq.size() == DEPTH) m_ovf = 1;
                if (bus.push && mq.size() < DEPTH) begin
                    mq.push_back(bus.push_data);
                    wcount++;
                end
            end
        end
    end

    task automatic step(input logic ps, input logic [DW-1:0] d, input logic pp);
        bus.push      = ps;
        bus.push_data = d;
        bus.pop       = pp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        got.delete();
        wadds.delete();
        radds.delete();
    endtask

    logic [DW-1:0] wrap_exp [8];

    initial begin
        total = 0;
        bad   = 0;
        ready = 0;
        rst   = 1'b1;
        bus.push = 1'b0;
        bus.push_data = '0;
        bus.pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("rst_flags", 32'({overflow, underflow}), 32'd0);

        // Fill then drain four words.
        clear_logs();
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("fd_n", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size())   chk("fd_data", 32'(got[i]), 32'(i));
            if (i < wadds.size()) chk("fd_wadd", 32'(wadds[i]), 32'(i));
            if (i < radds.size()) chk("fd_radd", 32'(radds[i]), 32'(i));
        end
        chk("fd_empty", 32'(empty), 32'd1);

        // Fill to capacity, then one push too many.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 1'b0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(bus.push_ready), 32'd0);
        bus.push = 1'b1;
        bus.push_data = 4'h9;
        #1;
        chk("full_no_wr", 32'(bus.ram_wr), 32'd0);
        step(1'b1, 4'h9, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);

        // Wrap-around of the write pointer.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        clear_logs();
        step(1'b1, 4'hA, 1'b0);
        step(1'b1, 4'hB, 1'b0);
        step(1'b1, 4'hC, 1'b0);
        chk("wrap_nw", 32'(wadds.size()), 32'd3);
        for (int i = 0; i < 3; i++) if (i < wadds.size()) chk("wrap_wadd", 32'(wadds[i]), 32'(i));
        got.delete();
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        wrap_exp = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC};
        chk("wrap_n", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++) if (i < got.size()) chk("wrap_data", 32'(got[i]), 32'(wrap_exp[i]));

        // Simultaneous push and pop with two entries stored.
        do_reset();
        step(1'b1, 4'h1, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        bus.push = 1'b1;
        bus.push_data = 4'h3;
        bus.pop = 1'b1;
        #1;
        chk("sim_rd", 32'(bus.ram_rd), 32'd1);
        chk("sim_wr", 32'(bus.ram_wr), 32'd0);
        chk("sim_ready", 32'(bus.push_ready), 32'd0);
        step(1'b1, 4'h3, 1'b1);
        chk("sim_count", 32'(count), 32'd1);

        // Pop from an empty FIFO.
        do_reset();
        bus.pop = 1'b1;
        #1;
        chk("uf_no_rd", 32'(bus.ram_rd), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("uf_set", 32'(underflow), 32'd1);
        chk("uf_pop_valid", 32'(bus.pop_valid), 32'd0);
        step(1'b0, '0, 1'b0);
        chk("uf_add", 32'(bus.ram_add), 32'd0);
        chk("uf_count", 32'(count), 32'd0);

        // Reset in the middle of traffic with a read in flight.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        rst = 1'b1;
        bus.push = 1'b1;
        bus.push_data = 4'hE;
        bus.pop = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.push_ready), 32'd0);
        chk("mid_rst_wr", 32'(bus.ram_wr), 32'd0);
        chk("mid_rst_rd", 32'(bus.ram_rd), 32'd0);
        step(1'b1, 4'hE, 1'b1);
        rst = 1'b0;
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("mid_flags", 32'({overflow, underflow}), 32'd0);
        bus.push = 1'b1;
        bus.push_data = 4'h7;
        bus.pop = 1'b0;
        #1;
        chk("mid_wadd", 32'(bus.ram_add), 32'd0);
        chk("mid_wr", 32'(bus.ram_wr), 32'd1);
        step(1'b1, 4'h7, 1'b1);
        step(1'b0, '0, 1'b0);

        // Random traffic with shifting push/pop bias and occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int bias;
            bias = (c / 250) % 4;
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            else rst = 1'b0;
            step(1'($urandom_range(0, 9) < 3 + 2 * bias),
                 4'($urandom),
                 1'($urandom_range(0, 9) < 8 - 2 * bias));
        end
        rst = 1'b0;
        step(1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
